test_seq_master: RTL and testbench

TEST_SEQ_MASTER -- requirements
Module: test_seq_master

---
 rtl/test_seq_master_if.sv | 23 ++
 rtl/test_seq_master.sv | 239 +++++++++++++++++++++++
 tb/tb_test_seq_master.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/test_seq_master_if.sv
// Avalon-MM master/slave bus between test_seq_master and the slave under test.
//   m_address   : 3-bit register address (0 go, 1 start addr, 2 num, 3 ID)
//   m_write     : write strobe
//   m_read      : read strobe (never high together with m_write)
//   m_writedata : 32-bit write data
//   m_readdata  : 32-bit read data, fixed read latency 1, no waitrequest
interface test_seq_master_if;
  logic [2:0]  m_address;
  logic        m_write;
  logic        m_read;
  logic [31:0] m_writedata;
  logic [31:0] m_readdata;

  modport master (
    output m_address, m_write, m_read, m_writedata,
    input  m_readdata
  );

  modport slave (
    input  m_address, m_write, m_read, m_writedata,
    output m_readdata
  );
endinterface

// File: rtl/test_seq_master.sv
// test_seq_master: runs one test pass against an Avalon-MM slave per start.
// A pass programs start address and num, reads num back, writes go, polls
// the go/running bit until it clears (or the poll limit is hit, in which case
// go is cleared), reads the ID register and pulses done.
//   avalon_clock   : single clock
//   resetn         : synchronous, active-low reset
//   start          : one-cycle pass request, only honoured in IDLE
//   cfg_start_addr : first RAM address to program (11 bits)
//   cfg_num        : end count to program (12 bits)
//   busy           : pass in progress (excludes the DONE cycle)
//   done           : one-cycle completion pulse
//   err_readback   : num readback mismatch (sticky until next start)
//   err_timeout    : poll limit exceeded (sticky until next start)
//   err_id         : ID register differs from ID_EXPECT (sticky until next start)
//   poll_count     : polls issued in the current or last pass
//   id_out         : last ID register value read
//   m              : Avalon-MM master bus
module test_seq_master #(
  parameter int unsigned POLL_LIMIT = 4095,
  parameter logic [31:0] ID_EXPECT  = 32'd1
) (
  input  logic                      avalon_clock,
  input  logic                      resetn,
  input  logic                      start,
  input  logic [10:0]               cfg_start_addr,
  input  logic [11:0]               cfg_num,
  output logic                      busy,
  output logic                      done,
  output logic                      err_readback,
  output logic                      err_timeout,
  output logic                      err_id,
  output logic [15:0]               poll_count,
  output logic [31:0]               id_out,
  test_seq_master_if.master         m
);

  localparam logic [31:0] LIMIT = 32'(POLL_LIMIT);

  localparam logic [2:0] REG_GO   = 3'd0;
  localparam logic [2:0] REG_ADDR = 3'd1;
  localparam logic [2:0] REG_NUM  = 3'd2;
  localparam logic [2:0] REG_ID   = 3'd3;

  typedef enum logic [3:0] {
    IDLE,
    WR_ADDR,
    WR_NUM,
    RD_NUM,
    RB_WAIT,
    WR_GO,
    POLL_RD,
    POLL_WAIT,
    RD_ID,
    ID_WAIT,
    ABORT,
    DONE
  } state_t;

  state_t      state_q, state_d;

  logic [10:0] addr_cfg_q, addr_cfg_d;
  logic [11:0] num_cfg_q, num_cfg_d;

  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_rb_q, err_rb_d;
  logic        err_to_q, err_to_d;
  logic        err_id_q, err_id_d;
  logic [15:0] poll_q, poll_d;
  logic [31:0] id_q, id_d;

  logic [2:0]  m_addr_q, m_addr_d;
  logic        m_wr_q, m_wr_d;
  logic        m_rd_q, m_rd_d;
  logic [31:0] m_wdata_q, m_wdata_d;

  // Next-state and registered-output logic. Outputs are decoded from the
  // state being entered, so they are valid for the whole cycle the FSM
  // occupies that state.
  always_comb begin
    state_d    = state_q;
    addr_cfg_d = addr_cfg_q;
    num_cfg_d  = num_cfg_q;
    err_rb_d   = err_rb_q;
    err_to_d   = err_to_q;
    err_id_d   = err_id_q;
    poll_d     = poll_q;
    id_d       = id_q;

    busy_d     = 1'b0;
    done_d     = 1'b0;
    m_addr_d   = '0;
    m_wr_d     = 1'b0;
    m_rd_d     = 1'b0;
    m_wdata_d  = '0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          addr_cfg_d = cfg_start_addr;
          num_cfg_d  = cfg_num;
          err_rb_d   = 1'b0;
          err_to_d   = 1'b0;
          err_id_d   = 1'b0;
          poll_d     = '0;
          state_d    = WR_ADDR;
        end
      end
      WR_ADDR: state_d = WR_NUM;
      WR_NUM:  state_d = RD_NUM;
      RD_NUM:  state_d = RB_WAIT;
      RB_WAIT: begin
        if (m.m_readdata[11:0] != num_cfg_q) begin
          err_rb_d = 1'b1;
          state_d  = DONE;
        end else begin
          state_d  = WR_GO;
        end
      end
      WR_GO:   state_d = POLL_RD;
      POLL_RD: state_d = POLL_WAIT;
      POLL_WAIT: begin
        if (!m.m_readdata[0]) begin
          state_d = RD_ID;
        end else if ({16'd0, poll_q} < LIMIT) begin
          state_d = POLL_RD;
        end else begin
          err_to_d = 1'b1;
          state_d  = ABORT;
        end
      end
      RD_ID:   state_d = ID_WAIT;
      ID_WAIT: begin
        id_d     = m.m_readdata;
        err_id_d = (m.m_readdata != ID_EXPECT);
        state_d  = DONE;
      end
      ABORT:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Count each poll as it is issued, so POLL_WAIT sees polls-so-far.
    if (state_d == POLL_RD && poll_q != 16'hFFFF) begin
      poll_d = poll_q + 16'd1;
    end

    busy_d = (state_d != IDLE) && (state_d != DONE);
    done_d = (state_d == DONE);

    unique case (state_d)
      WR_ADDR: begin
        m_wr_d    = 1'b1;
        m_addr_d  = REG_ADDR;
        m_wdata_d = {21'd0, addr_cfg_d};
      end
      WR_NUM: begin
        m_wr_d    = 1'b1;
        m_addr_d  = REG_NUM;
        m_wdata_d = {20'd0, num_cfg_d};
      end
      RD_NUM: begin
        m_rd_d    = 1'b1;
        m_addr_d  = REG_NUM;
      end
      WR_GO: begin
        m_wr_d    = 1'b1;
        m_addr_d  = REG_GO;
        m_wdata_d = 32'd1;
      end
      POLL_RD: begin
        m_rd_d    = 1'b1;
        m_addr_d  = REG_GO;
      end
      RD_ID: begin
        m_rd_d    = 1'b1;
        m_addr_d  = REG_ID;
      end
      ABORT: begin
        m_wr_d    = 1'b1;
        m_addr_d  = REG_GO;
        m_wdata_d = '0;
      end
      default: begin
        m_wr_d    = 1'b0;
        m_rd_d    = 1'b0;
        m_addr_d  = '0;
        m_wdata_d = '0;
      end
    endcase
  end

  always_ff @(posedge avalon_clock) begin
    if (!resetn) begin
      state_q    <= IDLE;
      addr_cfg_q <= '0;
      num_cfg_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_rb_q   <= 1'b0;
      err_to_q   <= 1'b0;
      err_id_q   <= 1'b0;
      poll_q     <= '0;
      id_q       <= '0;
      m_addr_q   <= '0;
      m_wr_q     <= 1'b0;
      m_rd_q     <= 1'b0;
      m_wdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_cfg_q <= addr_cfg_d;
      num_cfg_q  <= num_cfg_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_rb_q   <= err_rb_d;
      err_to_q   <= err_to_d;
      err_id_q   <= err_id_d;
      poll_q     <= poll_d;
      id_q       <= id_d;
      m_addr_q   <= m_addr_d;
      m_wr_q     <= m_wr_d;
      m_rd_q     <= m_rd_d;
      m_wdata_q  <= m_wdata_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign err_readback  = err_rb_q;
  assign err_timeout   = err_to_q;
  assign err_id        = err_id_q;
  assign poll_count    = poll_q;
  assign id_out        = id_q;
  assign m.m_address   = m_addr_q;
  assign m.m_write     = m_wr_q;
  assign m.m_read      = m_rd_q;
  assign m.m_writedata = m_wdata_q;

endmodule

// File: tb/tb_test_seq_master.sv
module tb_test_seq_master;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [10:0] cfg_start_addr;
  logic [11:0] cfg_num;
  logic        busy, done, err_readback, err_timeout, err_id;
  logic [15:0] poll_count;
  logic [31:0] id_out;

  test_seq_master_if bus ();

  test_seq_master #(
    .POLL_LIMIT (4),
    .ID_EXPECT  (32'd1)
  ) dut (
    .avalon_clock   (clk),
    .resetn         (resetn),
    .start          (start),
    .cfg_start_addr (cfg_start_addr),
    .cfg_num        (cfg_num),
    .busy           (busy),
    .done           (done),
    .err_readback   (err_readback),
    .err_timeout    (err_timeout),
    .err_id         (err_id),
    .poll_count     (poll_count),
    .id_out         (id_out),
    .m              (bus)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Slave model: register map with 1-cycle read latency.
  int unsigned busy_polls = 0;   // number of polls answered "running"
  logic [31:0] s_id       = 32'd1;
  bit          corrupt_rb = 1'b0;
  logic [10:0] s_addr     = '0;
  logic [11:0] s_num      = '0;
  int unsigned s_polls    = 0;
  int unsigned cyc        = 0;
  int unsigned done_cnt   = 0;
  bit          both_seen  = 1'b0;
  logic [2:0]  wlog_a[$];
  logic [31:0] wlog_d[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (bus.m_write && bus.m_read) both_seen <= 1'b1;
    bus.m_readdata <= '0;
    if (bus.m_write) begin
      wlog_a.push_back(bus.m_address);
      wlog_d.push_back(bus.m_writedata);
      case (bus.m_address)
        3'd0: if (bus.m_writedata[0]) s_polls <= 0;
        3'd1: s_addr <= bus.m_writedata[10:0];
        3'd2: s_num  <= bus.m_writedata[11:0];
        default: ;
      endcase
    end
    if (bus.m_read) begin
      case (bus.m_address)
        3'd0: begin
          bus.m_readdata <= {31'd0, (s_polls < busy_polls)};
          s_polls <= s_polls + 1;
        end
        3'd1: bus.m_readdata <= {21'd0, s_addr};
        3'd2: bus.m_readdata <= corrupt_rb ? 32'd17 : {20'd0, s_num};
        3'd3: bus.m_readdata <= s_id;
        default: bus.m_readdata <= '0;
      endcase
    end
  end

  task automatic check_zero(input string p);
    chk({p, "_busy"},   {31'd0, busy}, 32'd0);
    chk({p, "_done"},   {31'd0, done}, 32'd0);
    chk({p, "_errs"},   {29'd0, err_readback, err_timeout, err_id}, 32'd0);
    chk({p, "_polls"},  {16'd0, poll_count}, 32'd0);
    chk({p, "_id"},     id_out, 32'd0);
    chk({p, "_strobe"}, {30'd0, bus.m_write, bus.m_read}, 32'd0);
    chk({p, "_addr"},   {29'd0, bus.m_address}, 32'd0);
    chk({p, "_wdata"},  bus.m_writedata, 32'd0);
  endtask

  // Returns the edge on which done is first seen high, counted from the
  // start edge (done rises after edge k+9 in a one-poll pass, so lat=10).
  task automatic run_pass(input logic [10:0] a, input logic [11:0] n,
                          input bit repulse, output int lat);
    int unsigned k;
    @(negedge clk);
    cfg_start_addr = a;
    cfg_num        = n;
    start          = 1'b1;
    @(posedge clk);
    #1;
    k     = cyc;
    start = 1'b0;
    lat   = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (i == 0) chk("busy_run", {31'd0, busy}, 32'd1);
      if (repulse && i == 2) begin
        cfg_start_addr = 11'd7;
        cfg_num        = 12'd99;
        start          = 1'b1;
      end
      if (repulse && i == 3) start = 1'b0;
      if (done) begin
        lat = int'(cyc + 1 - k);
        break;
      end
    end
    if (lat < 0) chk("done_bound", 32'd0, 32'd1);
  endtask

  task automatic check_write(input string tag, input int unsigned idx,
                             input logic [2:0] a, input logic [31:0] d);
    if (idx < wlog_a.size()) begin
      chk({tag, "_a"}, {29'd0, wlog_a[idx]}, {29'd0, a});
      chk({tag, "_d"}, wlog_d[idx], d);
    end else begin
      chk({tag, "_missing"}, 32'd0, 32'd1);
    end
  endtask

  initial begin
    int lat;
    int unsigned w0;
    int unsigned d0;

    resetn = 1'b0;
    start = 1'b0;
    cfg_start_addr = '0;
    cfg_num = '0;
    repeat (3) @(negedge clk);
    check_zero("rst");
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // Three polls, ID matches.
    busy_polls = 2; s_id = 32'd1; corrupt_rb = 1'b0;
    w0 = wlog_a.size();
    run_pass(11'd0, 12'd16, 1'b0, lat);
    chk("p3_lat", lat, 32'd14);
    chk("p3_done", {31'd0, done}, 32'd1);
    chk("p3_busy_done", {31'd0, busy}, 32'd0);
    chk("p3_polls", {16'd0, poll_count}, 32'd3);
    chk("p3_id", id_out, 32'd1);
    chk("p3_errs", {29'd0, err_readback, err_timeout, err_id}, 32'd0);
    chk("p3_nwr", wlog_a.size() - w0, 32'd3);
    check_write("p3_w0", w0,     3'd1, 32'd0);
    check_write("p3_w1", w0 + 1, 3'd2, 32'd16);
    check_write("p3_w2", w0 + 2, 3'd0, 32'd1);
    repeat (2) @(negedge clk);

    // Readback mismatch: go never written.
    corrupt_rb = 1'b1;
    w0 = wlog_a.size();
    run_pass(11'd3, 12'd5, 1'b0, lat);
    chk("rb_lat", lat, 32'd5);
    chk("rb_err", {29'd0, err_readback, err_timeout, err_id}, 32'b100);
    chk("rb_polls", {16'd0, poll_count}, 32'd0);
    chk("rb_nwr", wlog_a.size() - w0, 32'd2);
    check_write("rb_w0", w0,     3'd1, 32'd3);
    check_write("rb_w1", w0 + 1, 3'd2, 32'd5);
    corrupt_rb = 1'b0;
    repeat (2) @(negedge clk);

    // Slave always running: 4 polls then abort write of go=0.
    busy_polls = 1000;
    w0 = wlog_a.size();
    run_pass(11'd10, 12'd200, 1'b0, lat);
    chk("to_lat", lat, 32'd15);
    chk("to_err", {29'd0, err_readback, err_timeout, err_id}, 32'b010);
    chk("to_polls", {16'd0, poll_count}, 32'd4);
    chk("to_nwr", wlog_a.size() - w0, 32'd4);
    check_write("to_w2", w0 + 2, 3'd0, 32'd1);
    check_write("to_w3", w0 + 3, 3'd0, 32'd0);
    chk("to_id_kept", id_out, 32'd1);
    repeat (2) @(negedge clk);

    // Instant finish (num <= start address), wrong ID.
    busy_polls = 0; s_id = 32'd2;
    run_pass(11'd20, 12'd10, 1'b0, lat);
    chk("id_lat", lat, 32'd10);
    chk("id_err", {29'd0, err_readback, err_timeout, err_id}, 32'b001);
    chk("id_val", id_out, 32'd2);
    chk("id_polls", {16'd0, poll_count}, 32'd1);
    repeat (2) @(negedge clk);

    // start re-pulsed while busy is ignored.
    s_id = 32'd1;
    w0 = wlog_a.size();
    d0 = done_cnt;
    run_pass(11'd5, 12'd6, 1'b1, lat);
    chk("rp_lat", lat, 32'd10);
    repeat (20) @(negedge clk);
    chk("rp_dones", done_cnt - d0, 32'd1);
    chk("rp_nwr", wlog_a.size() - w0, 32'd3);
    check_write("rp_w0", w0,     3'd1, 32'd5);
    check_write("rp_w1", w0 + 1, 3'd2, 32'd6);
    chk("rp_busy", {31'd0, busy}, 32'd0);

    // Reset during POLL_WAIT: no abort write, everything back to zero.
    busy_polls = 1000;
    @(negedge clk);
    cfg_start_addr = 11'd1; cfg_num = 12'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
        if (bus.m_read && bus.m_address == 3'd0) begin
          seen = 1'b1;
          break;
        end
        @(negedge clk);
      end
      chk("rs_poll_seen", {31'd0, seen}, 32'd1);
    end
    @(negedge clk);               // now in POLL_WAIT
    w0 = wlog_a.size();
    resetn = 1'b0;
    @(negedge clk);
    check_zero("rs");
    busy_polls = 0;
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    chk("rs_nwr", wlog_a.size() - w0, 32'd0);
    run_pass(11'd4, 12'd9, 1'b0, lat);
    chk("rs_lat", lat, 32'd10);
    chk("rs_errs", {29'd0, err_readback, err_timeout, err_id}, 32'd0);
    chk("rs_id", id_out, 32'd1);
    repeat (2) @(negedge clk);

    chk("no_both_strobes", {31'd0, both_seen}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
